df_diff_sat: RTL and testbench

Saturating first-difference stage for the digital filter datapath: y[n] = sat(x[n] − x[n−1]). It is the inverse counterpart of the non-overflowing adder/accumulator path. It converts an unsigned sample stream into a signed, range-limited difference stream. It sits between the sample source and the filter tap chain, with valid/ready handshakes on both sides and a two-stage pipeline.

---
 rtl/df_pkg.sv | 11 +
 rtl/df_sat_clamp.sv | 23 ++
 rtl/df_diff_sat.sv | 88 ++++++++
 tb/tb_df_diff_sat.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/df_pkg.sv
// Shared definitions for the digital filter datapath: sample width, signed limits
// and the widened difference type.
package df_pkg;

  localparam int unsigned DF_WIDTH = 8;
  localparam logic signed [DF_WIDTH-1:0] DF_SMAX = {1'b0, {(DF_WIDTH-1){1'b1}}};
  localparam logic signed [DF_WIDTH-1:0] DF_SMIN = {1'b1, {(DF_WIDTH-1){1'b0}}};

  typedef logic signed [DF_WIDTH:0] df_diff_t;

endpackage

// File: rtl/df_sat_clamp.sv
// Combinational clamp of a (WIDTH+1)-bit signed value to WIDTH-bit signed range,
// with a flag raised when clamping occurred.
module df_sat_clamp
  import df_pkg::*;
#(
  parameter int unsigned WIDTH = DF_WIDTH
) (
  input  logic signed [WIDTH:0]   din,
  output logic        [WIDTH-1:0] dout,
  output logic                    sat
);

  // Out of range exactly when the two top bits disagree; the sign bit picks the limit.
  always_comb begin
    dout = din[WIDTH-1:0];
    sat  = 1'b0;
    if (din[WIDTH] != din[WIDTH-1]) begin
      sat  = 1'b1;
      dout = din[WIDTH] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end

endmodule

// File: rtl/df_diff_sat.sv
// Saturating first-difference stage y[n] = sat(x[n] - x[n-1]) with a two-stage
// valid/ready pipeline and a sticky saturation event counter.
module df_diff_sat
  import df_pkg::*;
#(
  parameter int unsigned WIDTH     = DF_WIDTH,
  parameter int unsigned CNT_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WIDTH-1:0]     in_data,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_sat,
  output logic [CNT_WIDTH-1:0] sat_count
);

  logic [WIDTH-1:0]     prev;
  logic                 s1_valid;
  logic signed [WIDTH:0] s1_diff;
  logic                 s2_valid;
  logic [WIDTH-1:0]     s2_data;
  logic                 s2_sat;
  logic [WIDTH-1:0]     clamp_data;
  logic                 clamp_sat;
  logic                 s2_free;
  logic                 s1_adv;
  logic                 in_xfer;
  logic                 out_xfer;

  df_sat_clamp #(.WIDTH(WIDTH)) u_clamp (
    .din  (s1_diff),
    .dout (clamp_data),
    .sat  (clamp_sat)
  );

  // Reset and clear suppress both handshakes so nothing transfers in that cycle.
  assign s2_free   = !s2_valid || out_ready;
  assign s1_adv    = s1_valid && s2_free;
  assign in_ready  = !reset && !clear && (!s1_valid || s1_adv);
  assign out_valid = s2_valid && !reset && !clear;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;
  assign out_data  = s2_data;
  assign out_sat   = s2_sat;

  always_ff @(posedge clk) begin
    if (reset) begin
      prev      <= '0;
      s1_valid  <= 1'b0;
      s1_diff   <= '0;
      s2_valid  <= 1'b0;
      s2_data   <= '0;
      s2_sat    <= 1'b0;
      sat_count <= '0;
    end else if (clear) begin
      prev     <= '0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      if (in_xfer) begin
        prev    <= in_data;
        s1_diff <= $signed({1'b0, in_data}) - $signed({1'b0, prev});
      end

      if (in_xfer)
        s1_valid <= 1'b1;
      else if (s1_adv)
        s1_valid <= 1'b0;

      if (s1_adv) begin
        s2_valid <= 1'b1;
        s2_data  <= clamp_data;
        s2_sat   <= clamp_sat;
      end else if (out_xfer) begin
        s2_valid <= 1'b0;
      end

      if (out_xfer && s2_sat && (sat_count != '1))
        sat_count <= sat_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_df_diff_sat.sv
// Directed self-checking bench for df_diff_sat.
module tb_df_diff_sat;

  logic       clk = 1'b0;
  logic       reset;
  logic       clear;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_sat;
  logic [7:0] sat_count;

  int total = 0;
  int bad   = 0;

  df_diff_sat #(.WIDTH(8), .CNT_WIDTH(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .clear     (clear),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sat   (out_sat),
    .sat_count (sat_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  task automatic expect_out(input string tag, input logic [7:0] d, input logic s);
    chk({tag, ".valid"}, 32'(out_valid), 32'd1);
    chk({tag, ".data"},  32'(out_data),  32'(d));
    chk({tag, ".sat"},   32'(out_sat),   32'(s));
  endtask

  initial begin
    reset = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
    tick();
    tick();
    chk("rst.in_ready",  32'(in_ready),  32'd0);
    chk("rst.out_valid", 32'(out_valid), 32'd0);
    chk("rst.out_data",  32'(out_data),  32'd0);
    chk("rst.out_sat",   32'(out_sat),   32'd0);
    chk("rst.sat_count", 32'(sat_count), 32'd0);
    reset = 1'b0;
    #1;
    chk("post_rst.in_ready", 32'(in_ready), 32'd1);

    // 10, 30, 25 back to back -> 10, 20, -5
    push(8'd10);
    chk("t1.lat1", 32'(out_valid), 32'd0);
    push(8'd30);
    expect_out("t1.o0", 8'd10, 1'b0);
    push(8'd25);
    expect_out("t1.o1", 8'd20, 1'b0);
    in_valid = 1'b0;
    tick();
    expect_out("t1.o2", 8'hFB, 1'b0);
    tick();
    chk("t1.empty", 32'(out_valid), 32'd0);

    // 0, 255, 0 after clear -> 0, 127 sat, -128 sat
    clear = 1'b1;
    tick();
    clear = 1'b0;
    push(8'd0);
    push(8'd255);
    expect_out("t2.o0", 8'd0, 1'b0);
    push(8'd0);
    expect_out("t2.o1", 8'h7F, 1'b1);
    in_valid = 1'b0;
    tick();
    expect_out("t2.o2", 8'h80, 1'b1);
    tick();
    chk("t2.empty", 32'(out_valid), 32'd0);
    chk("t2.sat_count", 32'(sat_count), 32'd2);

    // stall: 100, 200 with out_ready low
    clear = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b0;
    push(8'd100);
    chk("t3.ready_after1", 32'(in_ready), 32'd1);
    push(8'd200);
    in_valid = 1'b1;
    in_data  = 8'd7;
    #1;
    chk("t3.ready_full", 32'(in_ready), 32'd0);
    expect_out("t3.hold0", 8'd100, 1'b0);
    tick();
    tick();
    expect_out("t3.hold1", 8'd100, 1'b0);
    chk("t3.ready_still", 32'(in_ready), 32'd0);
    tick();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    #1;
    expect_out("t3.drain0", 8'd100, 1'b0);
    tick();
    expect_out("t3.drain1", 8'd100, 1'b0);
    tick();
    chk("t3.empty", 32'(out_valid), 32'd0);

    // clear flushes in-flight samples and history
    push(8'd50);
    push(8'd60);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'd99;
    #1;
    chk("t4.ready_clear", 32'(in_ready), 32'd0);
    tick();
    clear    = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("t4.flushed", 32'(out_valid), 32'd0);
    push(8'd70);
    in_valid = 1'b0;
    #1;
    chk("t4.s1_only", 32'(out_valid), 32'd0);
    tick();
    expect_out("t4.o70", 8'd70, 1'b0);
    tick();
    chk("t4.empty", 32'(out_valid), 32'd0);

    // reset with both stages full
    out_ready = 1'b0;
    push(8'd1);
    push(8'd2);
    in_valid = 1'b0;
    #1;
    chk("t5.full_valid", 32'(out_valid), 32'd1);
    reset = 1'b1;
    tick();
    reset     = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("t5.valid",     32'(out_valid), 32'd0);
    chk("t5.sat_count", 32'(sat_count), 32'd0);
    chk("t5.in_ready",  32'(in_ready),  32'd1);
    push(8'd5);
    in_valid = 1'b0;
    tick();
    expect_out("t5.o5", 8'd5, 1'b0);
    tick();

    // 300 alternating samples: 299 clamped results, counter sticks at 255
    for (int i = 0; i < 300; i++)
      push((i % 2 == 0) ? 8'd0 : 8'd255);
    in_valid = 1'b0;
    tick();
    tick();
    tick();
    chk("t6.sat_count", 32'(sat_count), 32'hFF);
    chk("t6.empty",     32'(out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
